// File: rtl/axis_pkt_replay.sv
// AXI-Stream packet replay source: preload a beat buffer, then replay it with
// backpressure, inter-packet gap and repeat count. Optional macro PKT_REPLAY_LOOP_EN.
module axis_pkt_replay #(
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int DEPTH                = 16,
    parameter int GAP_W                = 16,
    parameter int REP_W                = 16,
    localparam int ADDR_W              = $clog2(DEPTH),
    localparam int KEEP_W              = C_M_AXIS_DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            aresetn,
    input  logic                            cfg_wr_en,
    input  logic [ADDR_W-1:0]               cfg_wr_addr,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]  cfg_wr_data,
    input  logic [KEEP_W-1:0]               cfg_wr_keep,
    input  logic                            cfg_wr_last,
    input  logic [ADDR_W:0]                 cfg_len,
    input  logic [GAP_W-1:0]                cfg_gap,
    input  logic [REP_W-1:0]                cfg_repeat,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0] cfg_tuser,
    input  logic                            start,
    input  logic                            stop,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0]               m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            done,
    output logic [31:0]                     pkt_cnt
);

`ifdef PKT_REPLAY_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [C_M_AXIS_DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [KEEP_W-1:0]              mem_keep [DEPTH];
    logic                           mem_last [DEPTH];

    state_t                          state_q, state_d;
    logic [ADDR_W:0]                 rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]                 len_q, len_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]                rep_left_q, rep_left_d;
    logic                            infinite_q, infinite_d;
    logic                            stop_pend_q, stop_pend_d;
    logic [31:0]                     pkt_cnt_q, pkt_cnt_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            tvalid_q, tvalid_d;
    logic                            tlast_q, tlast_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [KEEP_W-1:0]               tkeep_q, tkeep_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;

    logic            start_ok, hs, wrap, rep_done, finish, load_en;
    logic [ADDR_W:0] load_ptr, load_len;

    assign start_ok = start && (cfg_len != '0) && ((cfg_repeat != '0) || LOOP_EN);
    assign hs       = tvalid_q & m_axis_tready;
    assign wrap     = (rd_ptr_q == len_q - 1'b1);
    assign rep_done = wrap && !infinite_q && (rep_left_q == REP_W'(1));

    // NOTE: the beat buffer has no reset; its contents are don't-care until
    // software loads it, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (cfg_wr_en && state_q == IDLE) begin
            mem_data[cfg_wr_addr] <= cfg_wr_data;
            mem_keep[cfg_wr_addr] <= cfg_wr_keep;
            mem_last[cfg_wr_addr] <= cfg_wr_last;
        end
    end

    // NOTE: every signal driven here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        rep_left_d  = rep_left_q;
        infinite_d  = infinite_q;
        stop_pend_d = stop_pend_q;
        pkt_cnt_d   = pkt_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tuser_d     = tuser_q;
        finish      = 1'b0;
        load_en     = 1'b0;
        load_ptr    = rd_ptr_q;
        load_len    = len_q;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start_ok) begin
                    len_d      = cfg_len;
                    gap_d      = cfg_gap;
                    rep_left_d = cfg_repeat;
                    infinite_d = LOOP_EN && (cfg_repeat == '0);
                    tuser_d    = cfg_tuser;
                    rd_ptr_d   = '0;
                    pkt_cnt_d  = '0;
                    busy_d     = 1'b1;
                    tvalid_d   = 1'b1;
                    load_en    = 1'b1;
                    load_ptr   = '0;
                    load_len   = cfg_len;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (hs) begin
                    rd_ptr_d = wrap ? '0 : rd_ptr_q + 1'b1;
                    if (wrap && !infinite_q) rep_left_d = rep_left_q - 1'b1;
                    // Prefetch the following beat; it simply waits in the
                    // output registers if a gap or the end intervenes.
                    load_en  = 1'b1;
                    load_ptr = rd_ptr_d;
                    if (tlast_q) begin
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        if (rep_done || stop_pend_q || stop) begin
                            finish = 1'b1;
                        end else if (gap_q != '0) begin
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_q - 1'b1;
                            state_d   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (stop || stop_pend_q) begin
                    finish = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    tvalid_d = 1'b1;
                    state_d  = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d     = IDLE;
            tvalid_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
        end

        if (load_en) begin
            tdata_d = mem_data[load_ptr[ADDR_W-1:0]];
            tkeep_d = mem_keep[load_ptr[ADDR_W-1:0]];
            tlast_d = mem_last[load_ptr[ADDR_W-1:0]] | (load_ptr == load_len - 1'b1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            rep_left_q  <= '0;
            infinite_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            pkt_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tuser_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            rep_left_q  <= rep_left_d;
            infinite_q  <= infinite_d;
            stop_pend_q <= stop_pend_d;
            pkt_cnt_q   <= pkt_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tuser_q     <= tuser_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_replay.sv
// Self-checking bench for axis_pkt_replay: directed scenarios plus randomized
// replays, compared against a beat-list model built from the buffer contents.
module tb_axis_pkt_replay;

    localparam int DW    = 64;
    localparam int UW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int KW    = DW / 8;
    localparam int GW    = 8;
    localparam int RW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          aresetn;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_wr_addr;
    logic [DW-1:0] cfg_wr_data;
    logic [KW-1:0] cfg_wr_keep;
    logic          cfg_wr_last;
    logic [AW:0]   cfg_len;
    logic [GW-1:0] cfg_gap;
    logic [RW-1:0] cfg_repeat;
    logic [UW-1:0] cfg_tuser;
    logic          start, stop;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic          busy, done;
    logic [31:0]   pkt_cnt;

    axis_pkt_replay #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .DEPTH               (DEPTH),
        .GAP_W               (GW),
        .REP_W               (RW)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_wr_keep  (cfg_wr_keep),
        .cfg_wr_last  (cfg_wr_last),
        .cfg_len      (cfg_len),
        .cfg_gap      (cfg_gap),
        .cfg_repeat   (cfg_repeat),
        .cfg_tuser    (cfg_tuser),
        .start        (start),
        .stop         (stop),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .pkt_cnt      (pkt_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
        int            c;
    } beat_t;

    beat_t obs_q[$];
    beat_t hold;
    bit    hold_pend;
    int    cyc, n_cmp, n_err, done_cnt, done_cyc, tmode, start_cyc;

    logic [DW-1:0] mdl_data [DEPTH];
    logic [KW-1:0] mdl_keep [DEPTH];
    logic          mdl_last [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive tready after the edge, then observe at the falling edge.
    task automatic tick();
        beat_t b;
        @(posedge clk);
        cyc++;
        #1;
        case (tmode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
        @(negedge clk);
        if (aresetn && m_axis_tvalid) begin
            if (hold_pend) begin
                check("hold_data", m_axis_tdata, hold.d);
                check("hold_keep", m_axis_tkeep, hold.k);
                check("hold_last", m_axis_tlast, hold.l);
                check("hold_user", m_axis_tuser, hold.u);
            end
            b.d = m_axis_tdata;
            b.k = m_axis_tkeep;
            b.l = m_axis_tlast;
            b.u = m_axis_tuser;
            b.c = cyc;
            if (m_axis_tready) begin
                obs_q.push_back(b);
                hold_pend = 1'b0;
            end else begin
                hold      = b;
                hold_pend = 1'b1;
            end
        end else begin
            hold_pend = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic wr(input int a, input logic l);
        logic [DW-1:0] d = {$urandom, $urandom};
        logic [KW-1:0] k = KW'($urandom);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(a);
        cfg_wr_data = d;
        cfg_wr_keep = k;
        cfg_wr_last = l;
        tick();
        cfg_wr_en   = 1'b0;
        mdl_data[a] = d;
        mdl_keep[a] = k;
        mdl_last[a] = l;
    endtask

    task automatic start_replay(input int len, input int gap, input int rep,
                                input logic [UW-1:0] user, input int mode, input bit with_stop);
        obs_q.delete();
        done_cnt   = 0;
        done_cyc   = -1;
        hold_pend  = 1'b0;
        tmode      = mode;
        cfg_len    = (AW+1)'(len);
        cfg_gap    = GW'(gap);
        cfg_repeat = RW'(rep);
        cfg_tuser  = user;
        start      = 1'b1;
        stop       = with_stop;
        tick();
        start_cyc  = cyc;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
        check("done_seen", done_cnt != 0, 1);
        tick();
        tick();
    endtask

    // Expected stream: the buffer read in order, pass after pass, with the
    // final entry of each pass forced to close a packet.
    task automatic check_replay(input int len, input int gap, input int rep,
                                input logic [UW-1:0] user, input int mode,
                                input int limit, input int done_ofs);
        beat_t exp_q[$];
        beat_t e;
        int    pkts = 0;
        int    n;
        for (int p = 0; p < rep; p++) begin
            for (int i = 0; i < len; i++) begin
                if (limit < 0 || exp_q.size() < limit) begin
                    e.d = mdl_data[i];
                    e.k = mdl_keep[i];
                    e.l = mdl_last[i] || (i == len - 1);
                    e.u = user;
                    e.c = 0;
                    exp_q.push_back(e);
                    if (e.l) pkts++;
                end
            end
        end
        check("beat_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int j = 0; j < n; j++) begin
            check("beat_data", obs_q[j].d, exp_q[j].d);
            check("beat_keep", obs_q[j].k, exp_q[j].k);
            check("beat_last", obs_q[j].l, exp_q[j].l);
            check("beat_user", obs_q[j].u, exp_q[j].u);
        end
        if (obs_q.size() > 0) begin
            check("done_cyc", done_cyc, obs_q[obs_q.size()-1].c + done_ofs);
            if (mode == 0) begin
                check("first_beat_cyc", obs_q[0].c, start_cyc);
                for (int j = 1; j < obs_q.size(); j++)
                    check("beat_spacing", obs_q[j].c - obs_q[j-1].c,
                          obs_q[j-1].l ? gap + 1 : 1);
            end
        end
        check("done_cnt", done_cnt, 1);
        check("pkt_cnt", pkt_cnt, pkts);
        check("busy_end", busy, 0);
        check("tvalid_end", m_axis_tvalid, 0);
    endtask

    initial begin
        int len, gap, rep, mode;
        logic [UW-1:0] user;

        aresetn = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_wr_keep = '0; cfg_wr_last = 1'b0; cfg_len = '0; cfg_gap = '0;
        cfg_repeat = '0; cfg_tuser = '0; start = 1'b0; stop = 1'b0;
        m_axis_tready = 1'b1; tmode = 0; hold_pend = 1'b0;
        tick();
        tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        aresetn = 1'b1;
        tick();

        // Two packets, no backpressure; a stop alongside start is discarded.
        wr(0, 1'b0); wr(1, 1'b1); wr(2, 1'b0); wr(3, 1'b1);
        start_replay(4, 0, 1, 16'h0040, 0, 1'b1);
        check("busy_running", busy, 1);
        wait_done();
        check_replay(4, 0, 1, 16'h0040, 0, -1, 1);

        // Backpressure 1,0,0,1; a write and a start while busy must be ignored.
        start_replay(4, 0, 2, 16'h0040, 1, 1'b0);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = '0;
        cfg_wr_data = ~mdl_data[0];
        cfg_wr_keep = ~mdl_keep[0];
        cfg_len     = (AW+1)'(1);
        start       = 1'b1;
        tick();
        cfg_wr_en   = 1'b0;
        start       = 1'b0;
        wait_done();
        check_replay(4, 0, 2, 16'h0040, 1, -1, 1);

        // Gap of 20 between packets, three passes.
        wr(0, 1'b0); wr(1, 1'b1);
        start_replay(2, 20, 3, 16'h1234, 0, 1'b0);
        wait_done();
        check_replay(2, 20, 3, 16'h1234, 0, -1, 1);

        // Stop during packet 2: that packet completes, then the replay ends.
        start_replay(2, 0, 100, 16'h0bad, 0, 1'b0);
        for (int i = 0; i < 100 && obs_q.size() < 3; i++) tick();
        check("stop_point", obs_q.size(), 3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done();
        check_replay(2, 0, 100, 16'h0bad, 0, 4, 1);

        // Stop while in the gap ends the replay at once.
        start_replay(2, 10, 5, 16'h0077, 0, 1'b0);
        for (int i = 0; i < 100 && obs_q.size() < 2; i++) tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done();
        check_replay(2, 10, 5, 16'h0077, 0, 2, 2);

        // Asynchronous reset with a beat stalled on the bus.
        start_replay(2, 0, 1, 16'h0055, 3, 1'b0);
        tick();
        check("stalled_tvalid", m_axis_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_busy", busy, 0);
        check("arst_pkt_cnt", pkt_cnt, 0);
        tick();
        aresetn = 1'b1;
        tmode = 0;
        tick();
        check("post_rst_busy", busy, 0);
        wr(0, 1'b0); wr(1, 1'b1);
        start_replay(2, 0, 1, 16'h0055, 0, 1'b0);
        wait_done();
        check_replay(2, 0, 1, 16'h0055, 0, -1, 1);

        // Full-depth buffer with no last flags forms one packet.
        for (int i = 0; i < DEPTH; i++) wr(i, 1'b0);
        start_replay(DEPTH, 2, 1, 16'h00f0, 0, 1'b0);
        wait_done();
        check_replay(DEPTH, 2, 1, 16'h00f0, 0, -1, 1);

`ifndef PKT_REPLAY_LOOP_EN
        // A zero repeat count is rejected.
        cfg_len    = (AW+1)'(2);
        cfg_repeat = '0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("rep0_busy", busy, 0);
        check("rep0_tvalid", m_axis_tvalid, 0);
        tick();
        check("rep0_busy_later", busy, 0);
`endif

        // Randomized replays, alternating free-flowing and random tready.
        for (int t = 0; t < 6; t++) begin
            len  = $urandom_range(1, DEPTH);
            gap  = $urandom_range(0, 3);
            rep  = $urandom_range(1, 3);
            user = UW'($urandom);
            mode = (t % 2 == 0) ? 0 : 2;
            for (int i = 0; i < len; i++) wr(i, $urandom_range(0, 2) == 0);
            start_replay(len, gap, rep, user, mode, 1'b0);
            wait_done();
            check_replay(len, gap, rep, user, mode, -1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
